debounce_pulso: RTL and testbench

Conditions the raw mode push-button of the digital clock and emits exactly one clean, single-cycle `impulso` per accepted press. It feeds the mode selector, which advances its 0→1→2→0 mode on every clock cycle in which `impulso` is high. The block synchronises the asynchronous button, rejects bounce with a counter-qualified state machine, and optionally auto-repeats while the button is held.

---
 rtl/reloj_pkg.sv | 26 ++
 rtl/debounce_pulso_if.sv | 20 ++
 rtl/sincronizador.sv | 26 ++
 rtl/debounce_pulso.sv | 159 +++++++++++++++
 tb/tb_debounce_pulso.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/reloj_pkg.sv
// reloj_pkg: shared types and default timing constants for the digital-clock panel logic.
// Contents: debounce FSM state encoding, default cycle counts (50 MHz clock), max helper.
// Latency/backpressure: not applicable (declarations only).
package reloj_pkg;

   // Debounce FSM state encoding, kept as plain constants so legacy code can compare raw bits.
   typedef logic [1:0] estado_t;
   localparam estado_t IDLE            = 2'd0;
   localparam estado_t CONFIRM_PRESS   = 2'd1;
   localparam estado_t PRESSED         = 2'd2;
   localparam estado_t CONFIRM_RELEASE = 2'd3;

   // Default cycle counts for a 50 MHz clock.
   localparam int DEBOUNCE_CYCLES_DEF     = 500000;    // 10 ms
   localparam int REPEAT_DELAY_CYCLES_DEF = 25000000;  // 500 ms
   localparam int REPEAT_RATE_CYCLES_DEF  = 12500000;  // 250 ms

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/debounce_pulso_if.sv
// debounce_pulso_if: groups the button input with the conditioned pulse/level outputs.
// Signals: boton (raw button), impulso (one-cycle pulse), estable (debounced level).
// Modports: master = button/panel side driving boton; slave = debouncer side.
interface debounce_pulso_if;
   logic boton;
   logic impulso;
   logic estable;

   modport master (
      output boton,
      input  impulso,
      input  estable
   );

   modport slave (
      input  boton,
      output impulso,
      output estable
   );
endinterface

// File: rtl/sincronizador.sv
// sincronizador: two-flop synchroniser for one asynchronous level input, reusable for panel buttons.
// Ports: clock, reset (async active-high), async_i (raw input), sync_o (synchronised level).
// Latency: 2 clock edges from input change to sync_o; no backpressure.
module sincronizador (
   input  logic clock,
   input  logic reset,
   input  logic async_i,
   output logic sync_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

endmodule

// File: rtl/debounce_pulso.sv
// debounce_pulso: debounces the mode push-button and emits one single-cycle impulso per accepted press.
// Ports: clock, reset (async active-high), btn (slave modport: boton in, impulso/estable out).
// Latency: impulso/estable rise DEBOUNCE_CYCLES+2 edges after boton rises; no backpressure.
// Optional auto-repeat while held: define DEBOUNCE_PULSO_REPEAT_EN.
module debounce_pulso
   import reloj_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES     = DEBOUNCE_CYCLES_DEF,
   parameter int REPEAT_DELAY_CYCLES = REPEAT_DELAY_CYCLES_DEF,
   parameter int REPEAT_RATE_CYCLES  = REPEAT_RATE_CYCLES_DEF
) (
   input  logic             clock,
   input  logic             reset,
   debounce_pulso_if.slave  btn
);

`ifdef DEBOUNCE_PULSO_REPEAT_EN
   localparam bit REPEAT_EN = 1'b1;
`else
   localparam bit REPEAT_EN = 1'b0;
`endif

   // The counter only has to reach the largest terminal count in use.
   localparam int CNT_MAX = REPEAT_EN ? max3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES)
                                      : DEBOUNCE_CYCLES;
   localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef DEBOUNCE_PULSO_REPEAT_EN
   // A delay below 2 would put the first repeat right after the press pulse.
   localparam int DELAY_EFF = (REPEAT_DELAY_CYCLES < 2) ? 2 : REPEAT_DELAY_CYCLES;
   localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_EFF - 1);
   localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE_CYCLES - 1);
`endif

   logic             boton_sync;
   estado_t          estado_q, estado_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             impulso_q, impulso_d;
   logic             estable_q, estable_d;
`ifdef DEBOUNCE_PULSO_REPEAT_EN
   // 0: waiting for the initial hold delay; 1: spacing subsequent repeats.
   logic             rep_fase_q, rep_fase_d;
`endif

   sincronizador u_sync (
      .clock   (clock),
      .reset   (reset),
      .async_i (btn.boton),
      .sync_o  (boton_sync)
   );

   always_comb begin
      estado_d  = estado_q;
      cnt_d     = cnt_q;
      impulso_d = 1'b0;
      estable_d = estable_q;
`ifdef DEBOUNCE_PULSO_REPEAT_EN
      rep_fase_d = rep_fase_q;
`endif

      case (estado_q)
         IDLE: begin
            if (boton_sync) begin
               estado_d = CONFIRM_PRESS;
               cnt_d    = '0;
            end
         end

         CONFIRM_PRESS: begin
            if (!boton_sync) begin
               estado_d = IDLE;
               cnt_d    = '0;
            end else if (cnt_q == DEB_LAST) begin
               estado_d  = PRESSED;
               cnt_d     = '0;
               impulso_d = 1'b1;
               estable_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         PRESSED: begin
            if (!boton_sync) begin
               estado_d = CONFIRM_RELEASE;
               cnt_d    = '0;
            end else begin
`ifdef DEBOUNCE_PULSO_REPEAT_EN
               if ((!rep_fase_q && cnt_q == DELAY_LAST) ||
                   ( rep_fase_q && cnt_q == RATE_LAST)) begin
                  impulso_d  = 1'b1;
                  cnt_d      = '0;
                  rep_fase_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
`endif
            end
         end

         CONFIRM_RELEASE: begin
            // A bounce back to 1 returns to PRESSED silently; estable never dropped.
            if (boton_sync) begin
               estado_d = PRESSED;
               cnt_d    = '0;
            end else if (cnt_q == DEB_LAST) begin
               estado_d  = IDLE;
               cnt_d     = '0;
               estable_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            estado_d = IDLE;
            cnt_d    = '0;
         end
      endcase

`ifdef DEBOUNCE_PULSO_REPEAT_EN
      // Every entry into PRESSED comes from another state, so clearing here
      // restarts the hold delay on each (re-)entry.
      if (estado_q != PRESSED) begin
         rep_fase_d = 1'b0;
      end
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q  <= IDLE;
         cnt_q     <= '0;
         impulso_q <= 1'b0;
         estable_q <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         cnt_q     <= cnt_d;
         impulso_q <= impulso_d;
         estable_q <= estable_d;
      end
   end

`ifdef DEBOUNCE_PULSO_REPEAT_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rep_fase_q <= 1'b0;
      end else begin
         rep_fase_q <= rep_fase_d;
      end
   end
`endif

   assign btn.impulso = impulso_q;
   assign btn.estable = estable_q;

endmodule

// File: tb/tb_debounce_pulso.sv
// tb_debounce_pulso: directed self-checking bench for debounce_pulso (DEBOUNCE_CYCLES=4).
// Step k = k-th rising edge after boton is driven; outputs sampled 1 time unit after each edge.
// Repeat expectations (DELAY=10, RATE=3) apply only when DEBOUNCE_PULSO_REPEAT_EN is defined.
module tb_debounce_pulso;

   localparam int TB_DEB   = 4;
   localparam int TB_DELAY = 10;
   localparam int TB_RATE  = 3;

`ifdef DEBOUNCE_PULSO_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;

   int n_cmp  = 0;
   int n_fail = 0;

   debounce_pulso_if bus ();

   debounce_pulso #(
      .DEBOUNCE_CYCLES     (TB_DEB),
      .REPEAT_DELAY_CYCLES (TB_DELAY),
      .REPEAT_RATE_CYCLES  (TB_RATE)
   ) dut (
      .clock (clock),
      .reset (reset),
      .btn   (bus.slave)
   );

   always #5 clock = ~clock;

   // Drive boton, advance one rising edge, then settle before sampling.
   task automatic step(input logic b);
      bus.boton = b;
      @(posedge clock);
      #1;
   endtask

   // Expected repeat pulse at step k for a PRESSED stay entered at step e and left at step l.
   function automatic logic rep_hit(input int k, input int e, input int l);
      int j;
      j = k - e;
      if (!REP_EN || k <= e || k >= l) return 1'b0;
      if (j == TB_DELAY) return 1'b1;
      if (j > TB_DELAY && ((j - TB_DELAY) % TB_RATE) == 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic test_reset();
      bus.boton = 1'b0;
      #2;
      n_cmp++;
      if (bus.impulso !== 1'b0 || bus.estable !== 1'b0) begin
         $display("FAIL reset_initial impulso=%b estable=%b expected 0/0", bus.impulso, bus.estable);
         n_fail++;
      end
      step(1'b0);
      step(1'b0);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step(1'b0);
         n_cmp++;
         if (bus.impulso !== 1'b0 || bus.estable !== 1'b0) begin
            $display("FAIL reset_idle k=%0d impulso=%b estable=%b expected 0/0", k, bus.impulso, bus.estable);
            n_fail++;
         end
      end
      // Get to PRESSED, then reset between edges: estable must drop without a clock.
      for (int k = 0; k < 8; k++) step(1'b1);
      n_cmp++;
      if (bus.estable !== 1'b1) begin
         $display("FAIL reset_pre_pressed estable=%b expected 1", bus.estable);
         n_fail++;
      end
      #2;
      reset = 1'b1;
      #1;
      n_cmp++;
      if (bus.estable !== 1'b0 || bus.impulso !== 1'b0) begin
         $display("FAIL reset_async impulso=%b estable=%b expected 0/0", bus.impulso, bus.estable);
         n_fail++;
      end
      step(1'b0);
      step(1'b0);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) step(1'b0);
   endtask

   task automatic test_clean_press();
      logic b, ei, ee;
      for (int k = 0; k < 32; k++) begin
         b  = (k < 20);
         step(b);
         ei = (k == 6) || rep_hit(k, 6, 22);
         ee = (k >= 6 && k < 26);
         n_cmp++;
         if (bus.impulso !== ei) begin
            $display("FAIL clean_press impulso k=%0d got %b expected %b", k, bus.impulso, ei);
            n_fail++;
         end
         n_cmp++;
         if (bus.estable !== ee) begin
            $display("FAIL clean_press estable k=%0d got %b expected %b", k, bus.estable, ee);
            n_fail++;
         end
      end
   endtask

   task automatic test_bounce();
      logic b, ei, ee;
      for (int k = 0; k < 32; k++) begin
         b  = (k < 5) ? ((k % 2) == 0) : (k < 20);
         step(b);
         ei = (k == 10) || rep_hit(k, 10, 22);
         ee = (k >= 10 && k < 26);
         n_cmp++;
         if (bus.impulso !== ei) begin
            $display("FAIL bounce impulso k=%0d got %b expected %b", k, bus.impulso, ei);
            n_fail++;
         end
         n_cmp++;
         if (bus.estable !== ee) begin
            $display("FAIL bounce estable k=%0d got %b expected %b", k, bus.estable, ee);
            n_fail++;
         end
      end
   endtask

   task automatic test_glitch();
      for (int k = 0; k < 12; k++) begin
         step(k < 3);
         n_cmp++;
         if (bus.impulso !== 1'b0 || bus.estable !== 1'b0) begin
            $display("FAIL glitch k=%0d impulso=%b estable=%b expected 0/0", k, bus.impulso, bus.estable);
            n_fail++;
         end
      end
   endtask

   task automatic test_release_bounce();
      logic b, ei, ee;
      for (int k = 0; k < 32; k++) begin
         b  = (k < 12) || (k >= 14 && k < 22);
         step(b);
         ei = (k == 6) || rep_hit(k, 6, 14) || rep_hit(k, 16, 24);
         ee = (k >= 6 && k < 28);
         n_cmp++;
         if (bus.impulso !== ei) begin
            $display("FAIL release_bounce impulso k=%0d got %b expected %b", k, bus.impulso, ei);
            n_fail++;
         end
         n_cmp++;
         if (bus.estable !== ee) begin
            $display("FAIL release_bounce estable k=%0d got %b expected %b", k, bus.estable, ee);
            n_fail++;
         end
      end
   endtask

   task automatic test_reset_mid_confirm();
      logic ei, ee;
      // After step 5 the FSM sits one edge away from accepting the press.
      for (int k = 0; k < 6; k++) begin
         step(1'b1);
         n_cmp++;
         if (bus.impulso !== 1'b0) begin
            $display("FAIL mid_confirm_pre impulso k=%0d got %b expected 0", k, bus.impulso);
            n_fail++;
         end
      end
      #2;
      reset = 1'b1;
      #1;
      n_cmp++;
      if (bus.impulso !== 1'b0 || bus.estable !== 1'b0) begin
         $display("FAIL mid_confirm_async impulso=%b estable=%b expected 0/0", bus.impulso, bus.estable);
         n_fail++;
      end
      for (int k = 0; k < 2; k++) begin
         step(1'b1);
         n_cmp++;
         if (bus.impulso !== 1'b0 || bus.estable !== 1'b0) begin
            $display("FAIL mid_confirm_in_reset k=%0d impulso=%b estable=%b expected 0/0", k, bus.impulso, bus.estable);
            n_fail++;
         end
      end
      reset = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step(1'b1);
         ei = (k == 6);
         ee = (k >= 6);
         n_cmp++;
         if (bus.impulso !== ei) begin
            $display("FAIL mid_confirm_after impulso k=%0d got %b expected %b", k, bus.impulso, ei);
            n_fail++;
         end
         n_cmp++;
         if (bus.estable !== ee) begin
            $display("FAIL mid_confirm_after estable k=%0d got %b expected %b", k, bus.estable, ee);
            n_fail++;
         end
      end
      for (int k = 0; k < 12; k++) step(1'b0);
      n_cmp++;
      if (bus.estable !== 1'b0) begin
         $display("FAIL mid_confirm_release estable=%b expected 0", bus.estable);
         n_fail++;
      end
   endtask

   task automatic test_repeat();
      logic b, ei, ee;
      int   pulses;
      int   exp_pulses;
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         b  = (k < 30);
         step(b);
         ei = (k == 6) || rep_hit(k, 6, 32);
         ee = (k >= 6 && k < 36);
         if (bus.impulso === 1'b1) pulses++;
         n_cmp++;
         if (bus.impulso !== ei) begin
            $display("FAIL repeat impulso k=%0d got %b expected %b", k, bus.impulso, ei);
            n_fail++;
         end
         n_cmp++;
         if (bus.estable !== ee) begin
            $display("FAIL repeat estable k=%0d got %b expected %b", k, bus.estable, ee);
            n_fail++;
         end
      end
      // Held from press pulse at step 6 until PRESSED is left at step 32: 16, 19, 22, 25, 28, 31.
      exp_pulses = REP_EN ? 7 : 1;
      n_cmp++;
      if (pulses != exp_pulses) begin
         $display("FAIL repeat_count got %0d pulses expected %0d", pulses, exp_pulses);
         n_fail++;
      end
   endtask

   initial begin
      bus.boton = 1'b0;
      test_reset();
      test_clean_press();
      test_bounce();
      test_glitch();
      test_release_bounce();
      test_reset_mid_confirm();
      test_repeat();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
